// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the pipeline's MEM-stage port
// ("core") and a secondary loader/debug port ("dma"). At most one access is
// issued per cycle; simultaneous requests are resolved round-robin against the
// last granted requester. Read data returns one cycle after the read grant, to
// the requester that issued it.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-low reset
//   core_req/we/addr/wdata   core request (held until core_gnt)
//   core_gnt     core access issued this cycle
//   core_stall   core_req & ~core_gnt, to the hazard unit
//   core_rvalid/core_rdata   core read return (cycle after the read grant)
//   dma_req/we/addr/wdata    dma request (held until dma_gnt)
//   dma_gnt      dma access issued this cycle
//   dma_rvalid/dma_rdata     dma read return (cycle after the read grant)
//   mem_wr/mem_rd            memory write / read strobes
//   mem_addr/mem_wdata       memory address / write data (zero when idle)
//   mem_rdata    memory read data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DMA  = 1'b1
    } owner_t;

    owner_t            r_last_owner;
    owner_t            r_rd_owner;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_core_gnt;
    logic              w_dma_gnt;
    logic              w_mem_wr;
    logic              w_mem_rd;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_core_ret;
    logic              w_dma_ret;

    // Round-robin: on contention the requester that did not own the last
    // grant wins. Both grants are held low while reset is asserted so no
    // memory access can leak out during reset.
    assign w_core_gnt = reset & core_req & (~dma_req  | (r_last_owner == OWNER_DMA));
    assign w_dma_gnt  = reset & dma_req  & (~core_req | (r_last_owner == OWNER_CORE));

    always_comb begin
        w_mem_wr    = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_core_gnt) begin
            w_mem_wr    = core_we;
            w_mem_rd    = ~core_we;
            w_mem_addr  = core_addr;
            w_mem_wdata = core_wdata;
        end else if (w_dma_gnt) begin
            w_mem_wr    = dma_we;
            w_mem_rd    = ~dma_we;
            w_mem_addr  = dma_addr;
            w_mem_wdata = dma_wdata;
        end
    end

    // The memory presents read data in the cycle after mem_rd, so the return
    // is steered straight from mem_rdata while the pending read is marked.
    // Gating with reset suppresses a return that would coincide with reset.
    assign w_core_ret = reset & r_rd_pend & (r_rd_owner == OWNER_CORE);
    assign w_dma_ret  = reset & r_rd_pend & (r_rd_owner == OWNER_DMA);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_owner <= OWNER_DMA;   // core wins the first conflict
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= OWNER_CORE;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (w_core_gnt) begin
                r_last_owner <= OWNER_CORE;
            end else if (w_dma_gnt) begin
                r_last_owner <= OWNER_DMA;
            end
            r_rd_pend <= w_mem_rd;
            if (w_mem_rd) begin
                r_rd_owner <= w_dma_gnt ? OWNER_DMA : OWNER_CORE;
            end
            // Capture the returned word so rdata holds it once rvalid drops.
            if (w_core_ret) begin
                r_core_rdata <= mem_rdata;
            end
            if (w_dma_ret) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    assign core_gnt    = w_core_gnt;
    assign dma_gnt     = w_dma_gnt;
    assign core_stall  = core_req & ~w_core_gnt;
    assign mem_wr      = w_mem_wr;
    assign mem_rd      = w_mem_rd;
    assign mem_addr    = w_mem_addr;
    assign mem_wdata   = w_mem_wdata;
    assign core_rvalid = w_core_ret;
    assign dma_rvalid  = w_dma_ret;
    assign core_rdata  = w_core_ret ? mem_rdata : r_core_rdata;
    assign dma_rdata   = w_dma_ret  ? mem_rdata : r_dma_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline's MEM-stage load/store port ("core") and a secondary loader/debug port ("dma").
- Grants at most one access per cycle. Round-robin on contention.
- Returns read data one cycle after a read grant to the requester that issued it.
- Drives a stall to the pipeline while the core's access is held off.

Parameters:
- DATA_W, 32, data width of memory and both ports.
- ADDR_W, 9, word address width of the data memory.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req & ~core_gnt, combinational, to hazard unit
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- dma_req  in  1  dma access request, held until granted
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  dma address
- dma_wdata  in  DATA_W  dma write data
- dma_gnt  out  1  dma access issued this cycle
- dma_rvalid  out  1  dma read data valid
- dma_rdata  out  DATA_W  dma read data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_rd

Behaviour:
Reset (reset == 0 at posedge):
- last_owner <= DMA, so the core wins the first conflict.
- rd_pend <= 0, rd_owner <= CORE.
- Registered outputs are 0: core_rvalid, dma_rvalid, core_rdata, dma_rdata.
- Combinational grant outputs are forced 0 while reset is low.

Arbitration (combinational, same cycle):
- Only core_req: core_gnt = 1.
- Only dma_req: dma_gnt = 1.
- Both requesting: grant the requester that is not last_owner.
- Neither requesting: no grant; mem_wr = mem_rd = 0.
- core_gnt and dma_gnt are never both 1.

Memory drive:
- mem_addr and mem_wdata are muxed from the granted port; all-zero when idle.
- mem_wr = gnt & we; mem_rd = gnt & ~we.

State update (posedge, reset high):
- On any grant, last_owner <= granted requester. last_owner is unchanged when idle.
- rd_pend <= mem_rd; rd_owner <= granted requester when mem_rd is 1.

Read return:
- Read latency is exactly 1 cycle. In the cycle after a read grant, the owner's rvalid = 1 and its rdata = mem_rdata, both registered from mem_rdata on the next posedge.
- Implementation choice is free, but externally rvalid and rdata must be asserted together in cycle N+1 for a grant in cycle N. The non-owner's rvalid stays 0.
- rdata holds its last value when rvalid = 0.

Writes:
- Complete in the grant cycle. No rvalid is produced.

Handshake:
- A requester keeps req, we, addr and wdata stable until it sees gnt.
- It may deassert req or change fields the cycle after gnt.
- Back-to-back grants to the same requester are allowed when the other is idle.

Boundary conditions:
- Continuous contention alternates strictly, core/dma/core/dma. Worst-case core stall is 1 cycle per access.
- Read grant to one port followed next cycle by a grant to the other port: the rvalid of the first and the new access coexist without interference.
- Reset asserted mid-read: the pending rvalid is suppressed and no rvalid appears after reset releases.
- Address at 2^ADDR_W-1 passes unmodified. No wrap or translation is performed.

Test Plan:
- Reset then core-only read of addr 0x010, mem_rdata=0xDEADBEEF -> core_gnt=1 and mem_rd=1 in cycle 0; core_rvalid=1 and core_rdata=0xDEADBEEF in cycle 1; dma_rvalid=0 throughout.
- First cycle after reset, simultaneous core write 0x005/0x11111111 and dma read 0x006 -> core granted first (mem_wr=1, mem_addr=0x005, dma_stall implicit); dma granted next cycle; dma_rvalid one cycle after that.
- Both ports request reads for 6 cycles -> grants alternate C,D,C,D,C,D; core_stall=1 exactly on D cycles; each rvalid lands on its owner only.
- dma-only writes to 0x1FF for 3 consecutive cycles -> dma_gnt=1 every cycle, mem_addr=0x1FF, mem_wr=1, no rvalid pulses.
- Core read granted, reset low on the following edge -> core_rvalid stays 0 and all grants stay 0 during reset; after release, the first conflict goes to core.
- Idle cycle between accesses -> mem_wr=mem_rd=0, mem_addr=0, last_owner unchanged (verified by the next conflict outcome).
